gemm_mem_sequencer: RTL and testbench

Sequences multi-beat transfers between the GEMM datapath buffers and the 128-bit byte-masked memory port (`interface_*`).
- Accepts one command at a time: base byte address, byte length, direction.
- Splits the command into 16-byte beats. Each beat's byte count goes on `interface_control`, so the final partial beat is zero-masked by the memory.
- Streams beat data to and from the GEMM buffers over valid/ready.

---
 rtl/gemm_mem_sequencer.sv | 114 +++++++++++
 tb/tb_gemm_mem_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_mem_sequencer.sv
// gemm_mem_sequencer: splits a (addr, len, dir) command into 16-byte beats
// on the byte-masked memory port and streams them to/from the GEMM buffers.
// Optional build macro GEMM_MEMSEQ_RANGE_CHECK_EN rejects zero-length and
// out-of-range commands with an err pulse instead of done.
module gemm_mem_sequencer #(
  parameter int LEN_W     = 16,
  parameter int MEM_BYTES = 2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [127:0]     rd_data,
  output logic [4:0]       rd_bytes,
  output logic             rd_last,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [127:0]     wr_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             interface_en,
  output logic             interface_rdwr,
  output logic [31:0]      interface_addr,
  output logic [4:0]       interface_control,
  output logic [127:0]     interface_wr_data,
  input  logic [127:0]     interface_rd_data
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e           state_q;
  logic [31:0]      addr_q;
  logic [LEN_W-1:0] rem_q;
  logic             dir_q;
  logic [4:0]       beat;
  logic             run, beat_hs, reject, last_beat;

  // Beat size and handshake decode from the registered state
  assign run       = (state_q == RUN);
  assign beat      = (rem_q >= LEN_W'(16)) ? 5'd16 : rem_q[4:0];
  assign last_beat = (rem_q <= LEN_W'(16));
  assign beat_hs   = run && (dir_q ? wr_valid : rd_ready);

`ifdef GEMM_MEMSEQ_RANGE_CHECK_EN
  logic        rej_q;
  logic [32:0] end_addr;
  // 33-bit sum so a command wrapping past 2^32 is still caught as out of range
  assign end_addr = {1'b0, cmd_addr} + 33'(cmd_len);
  assign reject   = (cmd_len == '0) || (end_addr > 33'(MEM_BYTES));
  assign err      = (state_q == FIN) && rej_q;
  assign done     = (state_q == FIN) && !rej_q;
`else
  assign reject   = 1'b0;
  assign err      = 1'b0;
  assign done     = (state_q == FIN);
`endif

  // Command FSM: accept in IDLE, advance one beat per handshake in RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
`ifdef GEMM_MEMSEQ_RANGE_CHECK_EN
      rej_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          addr_q  <= cmd_addr;
          rem_q   <= cmd_len;
          dir_q   <= cmd_write;
`ifdef GEMM_MEMSEQ_RANGE_CHECK_EN
          rej_q   <= reject;
`endif
          state_q <= (cmd_len == '0 || reject) ? FIN : RUN;
        end
        RUN: if (beat_hs) begin
          addr_q <= addr_q + 32'd16;
          rem_q  <= rem_q - LEN_W'(beat);
          if (last_beat) state_q <= FIN;
        end
        default: begin
          state_q <= IDLE;
`ifdef GEMM_MEMSEQ_RANGE_CHECK_EN
          rej_q   <= 1'b0;
`endif
        end
      endcase
    end
  end

  // Output decode; address and payload hold whenever no handshake occurs
  assign cmd_ready         = (state_q == IDLE);
  assign busy              = (state_q != IDLE);
  assign rd_valid          = run && !dir_q;
  assign rd_data           = interface_rd_data;
  assign rd_bytes          = rd_valid ? beat : 5'd0;
  assign rd_last           = rd_valid && last_beat;
  assign wr_ready          = run && dir_q;
  assign interface_rdwr    = run && dir_q;
  assign interface_en      = run && (!dir_q || wr_valid);
  assign interface_addr    = addr_q;
  assign interface_control = run ? beat : 5'd0;
  assign interface_wr_data = wr_data;

endmodule

// File: tb/tb_gemm_mem_sequencer.sv
// Self-checking bench for gemm_mem_sequencer: byte-masked memory model plus a
// golden byte array; expected beats are derived from (addr, len) arithmetic.
module tb_gemm_mem_sequencer;
  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready, cmd_write;
  logic [31:0]  cmd_addr;
  logic [15:0]  cmd_len;
  logic         rd_valid, rd_ready, rd_last;
  logic [127:0] rd_data;
  logic [4:0]   rd_bytes;
  logic         wr_valid, wr_ready;
  logic [127:0] wr_data;
  logic         busy, done, err;
  logic         interface_en, interface_rdwr;
  logic [31:0]  interface_addr;
  logic [4:0]   interface_control;
  logic [127:0] interface_wr_data, interface_rd_data;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] mem  [0:4095] = '{default: 8'h00};
  logic [7:0] gmem [0:4095] = '{default: 8'h00};

  always #5 clk = ~clk;

  gemm_mem_sequencer #(.LEN_W(16), .MEM_BYTES(2000)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_bytes(rd_bytes), .rd_last(rd_last),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err),
    .interface_en(interface_en), .interface_rdwr(interface_rdwr),
    .interface_addr(interface_addr), .interface_control(interface_control),
    .interface_wr_data(interface_wr_data), .interface_rd_data(interface_rd_data)
  );

  // Memory model: byte-masked write commit on the clock edge
  always @(posedge clk) begin
    if (interface_en && interface_rdwr)
      for (int i = 0; i < 16; i++)
        if (i < int'(interface_control)) begin
          logic [31:0] a;
          a = interface_addr + 32'(i);
          mem[a[11:0]] <= interface_wr_data[8*i +: 8];
        end
  end

  // Memory model: combinational read from address
  always_comb begin
    interface_rd_data = '0;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a;
      a = interface_addr + 32'(i);
      interface_rd_data[8*i +: 8] = mem[a[11:0]];
    end
  end

  function automatic logic [127:0] gword(input logic [31:0] a);
    logic [127:0] r;
    logic [31:0]  t;
    for (int i = 0; i < 16; i++) begin
      t = a + 32'(i);
      r[8*i +: 8] = gmem[t[11:0]];
    end
    return r;
  endfunction

  task automatic issue(input logic [31:0] a, input int len, input logic w);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = 16'(len); cmd_write = w;
    #1;
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL issue_ready: got %b exp 1", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Run the beats of an accepted command; hs pattern first, then random stalls
  task automatic beats(input logic [31:0] a, input int len, input logic w,
                       input int pat_len, input logic [15:0] pat, input int stall_pct);
    int k, pi, stalls, eb;
    bit hs, rej, lastb;
    logic [31:0]  ea;
    logic [127:0] wd;
    rej = 1'b0;
`ifdef GEMM_MEMSEQ_RANGE_CHECK_EN
    rej = (len == 0) || (longint'(a) + longint'(len) > 64'd2000);
`endif
    if (len == 0 || rej) begin
      rd_ready = 1'b1; wr_valid = 1'b1; #1;
      n_chk++; if (done !== !rej) begin n_fail++; $display("FAIL nolen_done: got %b exp %b", done, !rej); end
      n_chk++; if (err !== rej) begin n_fail++; $display("FAIL nolen_err: got %b exp %b", err, rej); end
      n_chk++; if (interface_en !== 1'b0) begin n_fail++; $display("FAIL nolen_en: got %b exp 0", interface_en); end
      @(posedge clk); #1;
      rd_ready = 1'b0; wr_valid = 1'b0;
      n_chk++; if (cmd_ready !== 1'b1 || done !== 1'b0 || interface_en !== 1'b0) begin
        n_fail++; $display("FAIL nolen_idle: ready %b done %b en %b exp 1 0 0", cmd_ready, done, interface_en); end
      return;
    end
    k = 0; pi = 0; stalls = 0;
    while (k * 16 < len) begin
      ea    = a + 32'(k * 16);
      eb    = (len - k * 16 >= 16) ? 16 : len - k * 16;
      lastb = (len - k * 16 <= 16);
      if (pi < pat_len) hs = pat[pi];
      else hs = ($urandom_range(0, 99) >= stall_pct) || (stalls >= 6);
      pi++;
      wd = {$urandom, $urandom, $urandom, $urandom};
      wr_data  = wd;
      rd_ready = w ? 1'($urandom_range(0, 1)) : hs;
      wr_valid = w ? hs : 1'($urandom_range(0, 1));
      #1;
      n_chk++; if (busy !== 1'b1 || cmd_ready !== 1'b0 || done !== 1'b0) begin
        n_fail++; $display("FAIL run_status: busy %b ready %b done %b exp 1 0 0", busy, cmd_ready, done); end
      n_chk++; if (interface_addr !== ea) begin n_fail++; $display("FAIL beat_addr: got %h exp %h", interface_addr, ea); end
      n_chk++; if (interface_control !== 5'(eb)) begin n_fail++; $display("FAIL beat_ctrl: got %0d exp %0d", interface_control, eb); end
      n_chk++; if (interface_en !== (w ? hs : 1'b1) || interface_rdwr !== w) begin
        n_fail++; $display("FAIL beat_en: en %b rdwr %b exp %b %b", interface_en, interface_rdwr, (w ? hs : 1'b1), w); end
      if (!w) begin
        n_chk++; if (rd_valid !== 1'b1 || wr_ready !== 1'b0 || rd_bytes !== 5'(eb) || rd_last !== lastb) begin
          n_fail++; $display("FAIL rd_beat: valid %b wrdy %b bytes %0d last %b exp 1 0 %0d %b", rd_valid, wr_ready, rd_bytes, rd_last, eb, lastb); end
        n_chk++; if (rd_data !== gword(ea)) begin n_fail++; $display("FAIL rd_data: got %h exp %h", rd_data, gword(ea)); end
      end else begin
        n_chk++; if (wr_ready !== 1'b1 || rd_valid !== 1'b0 || interface_wr_data !== wd) begin
          n_fail++; $display("FAIL wr_beat: rdy %b rvld %b data %h exp 1 0 %h", wr_ready, rd_valid, interface_wr_data, wd); end
      end
      @(posedge clk); #1;
      if (hs) begin
        if (w) for (int i = 0; i < eb; i++) begin
          logic [31:0] t;
          t = ea + 32'(i);
          gmem[t[11:0]] = wd[8*i +: 8];
        end
        k++; stalls = 0;
      end else stalls++;
    end
    rd_ready = 1'b1; wr_valid = 1'b1; #1;
    n_chk++; if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL fin: done %b err %b busy %b ready %b exp 1 0 1 0", done, err, busy, cmd_ready); end
    n_chk++; if (interface_en !== 1'b0 || interface_control !== 5'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b0) begin
      n_fail++; $display("FAIL fin_port: en %b ctrl %0d rv %b wr %b exp 0 0 0 0", interface_en, interface_control, rd_valid, wr_ready); end
    @(posedge clk); #1;
    rd_ready = 1'b0; wr_valid = 1'b0;
    n_chk++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL post_fin: ready %b busy %b done %b exp 1 0 0", cmd_ready, busy, done); end
  endtask

  task automatic check_mem(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== gmem[i]) bad++;
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL mem_%s: %0d bytes differ exp 0", name, bad); end
  endtask

  task automatic test_reset;
    rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    rd_ready = 1'b0; wr_valid = 1'b0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: ready %b busy %b done %b err %b exp 1 0 0 0", cmd_ready, busy, done, err); end
    n_chk++; if (interface_en !== 1'b0 || interface_rdwr !== 1'b0 || interface_control !== 5'd0 || interface_addr !== 32'd0) begin
      n_fail++; $display("FAIL reset_port: en %b rdwr %b ctrl %0d addr %h exp 0 0 0 0", interface_en, interface_rdwr, interface_control, interface_addr); end
    n_chk++; if (rd_valid !== 1'b0 || rd_last !== 1'b0 || wr_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_strm: rv %b rl %b wr %b exp 0 0 0", rd_valid, rd_last, wr_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_fill;
    issue(32'h0, 256, 1'b1);
    beats(32'h0, 256, 1'b1, 0, 16'h0, 30);
    check_mem("fill");
  endtask

  task automatic test_read_basic;
    issue(32'h10, 40, 1'b0);
    beats(32'h10, 40, 1'b0, 0, 16'h0, 0);
  endtask

  task automatic test_write_partial;
    issue(32'h100, 20, 1'b1);
    beats(32'h100, 20, 1'b1, 3, 16'b110, 0);
    check_mem("partial");
    for (int i = 'h114; i < 'h120; i++) begin
      n_chk++; if (mem[i] !== 8'h00) begin n_fail++; $display("FAIL tail_zero: byte %h got %h exp 00", i, mem[i]); end
    end
  endtask

  task automatic test_read_stall;
    issue(32'h23, 32, 1'b0);
    beats(32'h23, 32, 1'b0, 4, 16'b1001, 0);
  endtask

  task automatic test_reset_mid;
    logic [127:0] wd;
    issue(32'h300, 48, 1'b1);
    beats_one: begin
      wd = {$urandom, $urandom, $urandom, $urandom};
      wr_data = wd; wr_valid = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) gmem['h300 + i] = wd[8*i +: 8];
    end
    wr_data = {$urandom, $urandom, $urandom, $urandom}; wr_valid = 1'b1; #1;
    n_chk++; if (interface_en !== 1'b1 || interface_addr !== 32'h310) begin
      n_fail++; $display("FAIL rstmid_pre: en %b addr %h exp 1 310", interface_en, interface_addr); end
    rst = 1'b0; #1;
    n_chk++; if (interface_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_en: got %b exp 0", interface_en); end
    @(posedge clk); #1;
    rst = 1'b1; wr_valid = 1'b0; #1;
    n_chk++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_idle: ready %b busy %b exp 1 0", cmd_ready, busy); end
    check_mem("rstmid");
    @(posedge clk); #1;
  endtask

  task automatic test_zero_len;
    issue(32'h40, 0, 1'b1);
    beats(32'h40, 0, 1'b1, 0, 16'h0, 0);
    issue(32'h40, 0, 1'b0);
    beats(32'h40, 0, 1'b0, 0, 16'h0, 0);
`ifdef GEMM_MEMSEQ_RANGE_CHECK_EN
    issue(32'd1990, 16, 1'b1);
    beats(32'd1990, 16, 1'b1, 0, 16'h0, 0);
    issue(32'd1984, 16, 1'b1);
    beats(32'd1984, 16, 1'b1, 0, 16'h0, 0);
`endif
    check_mem("zero");
  endtask

  task automatic test_back_to_back;
    issue(32'h05, 33, 1'b0);
    cmd_valid = 1'b1; cmd_addr = 32'h80; cmd_len = 16'd17; cmd_write = 1'b0;
    beats(32'h05, 33, 1'b0, 0, 16'h0, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    beats(32'h80, 17, 1'b0, 0, 16'h0, 0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 25; n++) begin
      logic [31:0] a;
      int   len;
      logic w;
      a   = 32'($urandom_range(0, 1880));
      len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 110));
      w   = 1'($urandom_range(0, 1));
      issue(a, len, w);
      beats(a, len, w, 0, 16'h0, 35);
    end
    check_mem("random");
  endtask

  initial begin
    test_reset;
    test_write_fill;
    test_read_basic;
    test_write_partial;
    test_read_stall;
    test_reset_mid;
    test_zero_len;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
